// File: rtl/usb_tx.sv
// USB full-speed transmitter: SYNC/PID/payload/CRC16 serializer with bit
// stuffing, NRZI line coding and EOP generation on D+/D-.
module usb_tx #(
  parameter int CLKS_PER_BIT = 8,
  parameter int MAX_PAYLOAD  = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] tx_packet,
  input  logic [6:0] buffer_occupancy,
  input  logic [7:0] tx_packet_data,
  output logic       get_tx_packet_data,
  output logic       dp_out,
  output logic       dm_out,
  output logic       tx_transfer_active,
  output logic       tx_error
);
  localparam int          CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam int unsigned MAXP = MAX_PAYLOAD;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SYNC    = 3'd1;
  localparam logic [2:0] S_PID     = 3'd2;
  localparam logic [2:0] S_DATA    = 3'd3;
  localparam logic [2:0] S_CRC_LO  = 3'd4;
  localparam logic [2:0] S_CRC_HI  = 3'd5;
  localparam logic [2:0] S_EOP_SE0 = 3'd6;
  localparam logic [2:0] S_EOP_J   = 3'd7;

  logic [2:0]    state;
  logic [2:0]    bit_idx;     // index of the field bit currently on the line
  logic [7:0]    shreg;       // current payload byte
  logic [7:0]    pid_q;
  logic          is_data;
  logic [6:0]    byte_cnt;    // payload bytes not yet popped
  logic [15:0]   crc;         // reflected CRC16 register
  logic [2:0]    ones;        // run of consecutive 1 data bits
  logic [CW-1:0] clk_cnt;
  logic          line;        // 1 = J, 0 = K
  logic          get_q;
  logic          err_q;

  logic [2:0] nxt_idx;
  logic       fbit;
  logic [2:0] adv_state;
  logic       adv_bit;
  logic       adv_emit;
  logic       adv_pop;
  logic [7:0] pid_byte;
  logic       req_go;
  logic       req_bad;

  // Reflected form of x^16+x^15+x^2+1, one bit per call.
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    crc_step = {1'b0, c[15:1]} ^ ((c[0] ^ b) ? 16'hA001 : 16'h0000);
  endfunction

  // Decode a request into PID byte and legality.
  always_comb begin
    pid_byte = 8'h00;
    req_go   = 1'b0;
    req_bad  = 1'b0;
    case (tx_packet)
      3'd1:    pid_byte = 8'hC3;
      3'd2:    pid_byte = 8'h4B;
      3'd3:    pid_byte = 8'hD2;
      3'd4:    pid_byte = 8'h5A;
      3'd5:    pid_byte = 8'h1E;
      default: pid_byte = 8'h00;
    endcase
    if (tx_packet == 3'd6 || tx_packet == 3'd7)
      req_bad = 1'b1;
    else if ((tx_packet == 3'd1 || tx_packet == 3'd2) && 32'(buffer_occupancy) > MAXP)
      req_bad = 1'b1;
    else if (tx_packet != 3'd0)
      req_go = 1'b1;
  end

  // Pick the next unstuffed bit: within the field, or bit 0 of the next field.
  // A new payload byte's first bit is peeked from the buffer head; the byte
  // itself is captured under the pop strobe a cycle later.
  always_comb begin
    nxt_idx = bit_idx + 3'd1;
    fbit    = 1'b0;
    case (state)
      S_SYNC:   fbit = (nxt_idx == 3'd7);
      S_PID:    fbit = pid_q[nxt_idx];
      S_DATA:   fbit = shreg[nxt_idx];
      S_CRC_LO: fbit = ~crc[{1'b0, nxt_idx}];
      S_CRC_HI: fbit = ~crc[{1'b1, nxt_idx}];
      default:  fbit = 1'b0;
    endcase
    adv_state = state;
    adv_bit   = fbit;
    adv_emit  = 1'b1;
    adv_pop   = 1'b0;
    if (bit_idx == 3'd7) begin
      case (state)
        S_SYNC: begin adv_state = S_PID; adv_bit = pid_q[0]; end
        S_PID, S_DATA: begin
          if (state == S_PID && !is_data) begin
            adv_state = S_EOP_SE0; adv_emit = 1'b0;
          end else if (byte_cnt == 7'd0) begin
            adv_state = S_CRC_LO; adv_bit = ~crc[0];
          end else begin
            adv_state = S_DATA; adv_bit = tx_packet_data[0]; adv_pop = 1'b1;
          end
        end
        S_CRC_LO: begin adv_state = S_CRC_HI; adv_bit = ~crc[8]; end
        S_CRC_HI: begin adv_state = S_EOP_SE0; adv_emit = 1'b0; end
        default:  adv_emit = 1'b0;
      endcase
    end
  end

  // Packet sequencer, bit timer, stuffing, CRC and NRZI line state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      bit_idx  <= 3'd0;
      shreg    <= 8'h00;
      pid_q    <= 8'h00;
      is_data  <= 1'b0;
      byte_cnt <= 7'd0;
      crc      <= 16'h0000;
      ones     <= 3'd0;
      clk_cnt  <= '0;
      line     <= 1'b1;
      get_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      get_q <= 1'b0;
      err_q <= 1'b0;
      if (get_q) shreg <= tx_packet_data;
      if (state == S_IDLE) begin
        line    <= 1'b1;
        clk_cnt <= '0;
        bit_idx <= 3'd0;
        if (req_bad) begin
          err_q <= 1'b1;
        end else if (req_go) begin
          state    <= S_SYNC;
          pid_q    <= pid_byte;
          is_data  <= (tx_packet == 3'd1) || (tx_packet == 3'd2);
          byte_cnt <= buffer_occupancy;
          crc      <= 16'hFFFF;
          ones     <= 3'd0;
          line     <= 1'b0;  // first SYNC bit is a 0: J -> K
        end
      end else if (clk_cnt != LAST) begin
        clk_cnt <= clk_cnt + 1'b1;
      end else begin
        clk_cnt <= '0;
        case (state)
          S_EOP_SE0: begin
            bit_idx <= nxt_idx;
            if (bit_idx[0]) begin
              state   <= S_EOP_J;
              bit_idx <= 3'd0;
            end
          end
          S_EOP_J: begin
            state   <= S_IDLE;
            bit_idx <= 3'd0;
          end
          default: begin
            if (ones == 3'd6) begin
              line <= ~line;  // stuffed 0, field position unchanged
              ones <= 3'd0;
            end else begin
              state   <= adv_state;
              bit_idx <= nxt_idx;
              if (adv_emit) begin
                line <= adv_bit ? line : ~line;
                ones <= adv_bit ? ones + 3'd1 : 3'd0;
              end else begin
                line <= 1'b1;  // EOP_J drives J after SE0
              end
              if (adv_state == S_DATA) crc <= crc_step(crc, adv_bit);
              if (adv_pop) begin
                get_q    <= 1'b1;
                byte_cnt <= byte_cnt - 7'd1;
              end
            end
          end
        endcase
      end
    end
  end

  assign dp_out             = (state == S_EOP_SE0) ? 1'b0 : line;
  assign dm_out             = (state == S_EOP_SE0) ? 1'b0 : ~line;
  assign tx_transfer_active = (state != S_IDLE);
  assign get_tx_packet_data = get_q;
  assign tx_error           = err_q;
endmodule

// File: tb/tb_usb_tx.sv
// Bench for usb_tx: per-cycle comparison of lines/strobes against a
// bit-stream reference model (byte list -> CRC -> stuffing -> NRZI).
module tb_usb_tx;
  localparam int CPB = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] tx_packet;
  logic [6:0] buffer_occupancy;
  logic [7:0] tx_packet_data;
  logic       get_tx_packet_data;
  logic       dp_out;
  logic       dm_out;
  logic       tx_transfer_active;
  logic       tx_error;

  int vecs = 0;
  int errs = 0;

  logic [7:0] buf_mem [0:127];
  logic [6:0] rd_ptr = '0;
  logic [7:0] pl [0:127];
  logic [4:0] expq [$];

  usb_tx #(.CLKS_PER_BIT(CPB), .MAX_PAYLOAD(64)) dut (
    .clk(clk), .rst(rst), .tx_packet(tx_packet),
    .buffer_occupancy(buffer_occupancy), .tx_packet_data(tx_packet_data),
    .get_tx_packet_data(get_tx_packet_data), .dp_out(dp_out), .dm_out(dm_out),
    .tx_transfer_active(tx_transfer_active), .tx_error(tx_error)
  );

  always #5 clk = ~clk;

  // Endpoint buffer model: head byte visible, advanced by each pop.
  assign tx_packet_data = buf_mem[rd_ptr];
  always @(posedge clk) if (get_tx_packet_data === 1'b1) rd_ptr <= rd_ptr + 7'd1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] obs();
    return {27'd0, tx_error, tx_transfer_active, dp_out, dm_out, get_tx_packet_data};
  endfunction

  // Expected per-cycle {err, active, dp, dm, pop} for one packet.
  task automatic build(input logic [2:0] pkt, input int n);
    logic [7:0] bl [$];
    bit raw [$];
    bit fst [$];
    logic [15:0] c;
    bit lvl;
    int ones;
    bit data;
    bit fb;
    expq.delete();
    data = (pkt == 3'd1) || (pkt == 3'd2);
    bl.push_back(8'h80);
    case (pkt)
      3'd1: bl.push_back(8'hC3);
      3'd2: bl.push_back(8'h4B);
      3'd3: bl.push_back(8'hD2);
      3'd4: bl.push_back(8'h5A);
      default: bl.push_back(8'h1E);
    endcase
    if (data) for (int k = 0; k < n; k++) bl.push_back(pl[k]);
    c = 16'hFFFF;
    foreach (bl[k]) for (int b = 0; b < 8; b++) begin
      raw.push_back(bl[k][b]);
      fst.push_back(k >= 2 && b == 0);
      if (k >= 2) begin  // MSB-first CRC over the wire-order bit stream
        fb = c[15] ^ bl[k][b];
        c = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
      end
    end
    if (data) for (int b = 15; b >= 0; b--) begin
      raw.push_back(~c[b]);
      fst.push_back(1'b0);
    end
    lvl = 1'b1;
    ones = 0;
    foreach (raw[i]) begin
      if (!raw[i]) lvl = ~lvl;
      for (int k = 0; k < CPB; k++) expq.push_back({2'b01, lvl, ~lvl, fst[i] && k == 0});
      ones = raw[i] ? ones + 1 : 0;
      if (ones == 6) begin
        lvl = ~lvl;
        for (int k = 0; k < CPB; k++) expq.push_back({2'b01, lvl, ~lvl, 1'b0});
        ones = 0;
      end
    end
    for (int k = 0; k < 2 * CPB; k++) expq.push_back(5'b01000);
    for (int k = 0; k < CPB; k++) expq.push_back(5'b01100);
  endtask

  // Issue one request at a negedge and compare every cycle of the packet.
  task automatic run_pkt(input logic [2:0] pkt, input int n, input int abort_st,
                         input bit wiggle, output int act, output int nst,
                         output int s0, output int s1);
    int post;
    logic [31:0] o;
    act = 0; nst = 0; s0 = 0; s1 = 0; post = 0;
    build(pkt, n);
    for (int i = 0; i < n; i++) buf_mem[rd_ptr + 7'(i)] = pl[i];
    tx_packet = pkt;
    buffer_occupancy = 7'(n);
    @(posedge clk);
    for (int cyc = 0; cyc < expq.size(); cyc++) begin
      @(negedge clk);
      o = obs();
      chk("line", o, 32'(expq[cyc]));
      if (o[3]) act++;
      if (o[0]) begin
        if (nst == 0) s0 = cyc;
        if (nst == 1) s1 = cyc;
        nst++;
      end
      if (wiggle && cyc < expq.size() - 1) begin
        tx_packet = 3'($urandom);
        buffer_occupancy = 7'($urandom);
      end else begin
        tx_packet = 3'd0;
      end
      if (abort_st != 0 && nst >= abort_st) begin
        post++;
        if (post == 5) begin
          rst = 1'b1;
          @(negedge clk);
          chk("mid_rst", obs(), 32'b00100);
          rst = 1'b0;
          return;
        end
      end
    end
    @(negedge clk);
    chk("idle_after", obs(), 32'b00100);
  endtask

  task automatic illegal(input logic [2:0] pkt, input logic [6:0] occ);
    tx_packet = pkt;
    buffer_occupancy = occ;
    @(posedge clk);
    @(negedge clk);
    tx_packet = 3'd0;
    chk("err_pulse", obs(), 32'b10100);
    @(negedge clk);
    chk("err_clear", obs(), 32'b00100);
  endtask

  initial begin
    int act, nst, s0, s1, n;
    logic [2:0] p;
    for (int i = 0; i < 128; i++) buf_mem[i] = 8'h00;
    rst = 1'b1;
    tx_packet = 3'd0;
    buffer_occupancy = 7'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset", obs(), 32'b00100);
    rst = 1'b0;
    @(negedge clk);

    run_pkt(3'd3, 0, 0, 1'b0, act, nst, s0, s1);
    chk("ack_len", act, 152);
    chk("ack_pops", nst, 0);

    run_pkt(3'd1, 0, 0, 1'b0, act, nst, s0, s1);
    chk("zlp_len", act, 280);
    chk("zlp_pops", nst, 0);

    pl[0] = 8'hFF; pl[1] = 8'hFF;
    run_pkt(3'd2, 2, 0, 1'b0, act, nst, s0, s1);
    chk("ff_pops", nst, 2);
    chk("ff_gap", s1 - s0, 72);

    illegal(3'd6, 7'd0);
    illegal(3'd7, 7'd3);
    illegal(3'd1, 7'd65);
    illegal(3'd2, 7'd127);

    for (int i = 0; i < 10; i++) pl[i] = 8'($urandom);
    run_pkt(3'd1, 10, 3, 1'b0, act, nst, s0, s1);
    chk("rst_pops", nst, 3);
    @(negedge clk);
    run_pkt(3'd3, 0, 0, 1'b0, act, nst, s0, s1);
    chk("ack2_len", act, 152);

    run_pkt(3'd4, 0, 0, 1'b1, act, nst, s0, s1);
    run_pkt(3'd5, 0, 0, 1'b0, act, nst, s0, s1);

    for (int i = 0; i < 64; i++) pl[i] = 8'($urandom);
    run_pkt(3'd2, 64, 0, 1'b0, act, nst, s0, s1);
    chk("max_pops", nst, 64);

    repeat (12) begin
      p = 3'(1 + $urandom_range(0, 4));
      n = $urandom_range(0, 16);
      for (int i = 0; i < n; i++) pl[i] = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
      run_pkt(p, n, 0, 1'($urandom), act, nst, s0, s1);
      chk("rnd_pops", nst, (p <= 3'd2) ? n : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
